// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Shares one SRAM-like memory port between the instruction
//               fetch requester (IF) and the data requester (EX). One
//               requester is granted at a time. The source of every accepted
//               request is pushed into an in-order tag FIFO, and returning
//               responses are steered to the owner of the oldest outstanding
//               transaction.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : OUTSTANDING - maximum accepted-but-unanswered transactions
//                             (tag FIFO depth, power of two, >= 1)
// Macro       : MEM_ARB_RR_EN - when defined, a tie between IF and data is
//                             resolved round-robin (reset favours data);
//                             otherwise data always wins a tie.
// Ports       : clk, resetn          - clock, synchronous active-low reset
//               inst_*_i / inst_*_o  - IF request/response (read only)
//               data_*_i / data_*_o  - EX load/store request/response
//               mem_*_o / mem_*_i    - shared downstream memory port
// ============================================================================
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    // IF requester
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    input  logic [1:0]  inst_size_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata_o,
    // EX requester
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [3:0]  data_wstrb_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o,
    // Shared memory port
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_size_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_addr_ok_i,
    input  logic        mem_data_ok_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               tags_q [OUTSTANDING];   // 0 = IF, 1 = data

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_pick_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_full  = (count_q == CNT_W'(OUTSTANDING));
    assign w_empty = (count_q == '0);
    assign w_push  = (state_q != S_IDLE) && mem_addr_ok_i;
    assign w_pop   = mem_data_ok_i && !w_empty;
    assign w_head  = tags_q[rd_ptr_q];

`ifdef MEM_ARB_RR_EN
    // 1 = data has priority on the next tie.
    logic rr_data_q;

    assign w_pick_data = data_req_i && (!inst_req_i || rr_data_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_data_q <= 1'b1;
        end else if (w_push) begin
            // Favour whichever requester did not just win.
            rr_data_q <= (state_q == S_GRANT_I);
        end
    end
`else
    assign w_pick_data = data_req_i;
`endif

    // Next-state and FIFO bookkeeping. Fullness uses the registered count,
    // so a pop in the same cycle only frees a slot for the following cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (!w_full && (inst_req_i || data_req_i)) begin
                    state_d = w_pick_data ? S_GRANT_D : S_GRANT_I;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (mem_addr_ok_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                tags_q[i] <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (w_push) begin
                tags_q[wr_ptr_q] <= (state_q == S_GRANT_D);
            end
        end
    end

    // Downstream request fields follow the granted requester; IF never writes.
    always_comb begin
        mem_req_o   = (state_q != S_IDLE);
        mem_wr_o    = 1'b0;
        mem_size_o  = 2'd0;
        mem_wstrb_o = 4'd0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        case (state_q)
            S_GRANT_I: begin
                mem_size_o = inst_size_i;
                mem_addr_o = inst_addr_i;
            end
            S_GRANT_D: begin
                mem_wr_o    = data_wr_i;
                mem_size_o  = data_size_i;
                mem_wstrb_o = data_wstrb_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end
            default: ;
        endcase
    end

    // Handshake and response outputs are forced low while reset is asserted.
    assign inst_addr_ok_o = resetn && (state_q == S_GRANT_I) && mem_addr_ok_i;
    assign data_addr_ok_o = resetn && (state_q == S_GRANT_D) && mem_addr_ok_i;
    assign inst_data_ok_o = resetn && w_pop && !w_head;
    assign data_data_ok_o = resetn && w_pop &&  w_head;
    assign inst_rdata_o   = mem_rdata_i & {32{resetn}};
    assign data_rdata_o   = mem_rdata_i & {32{resetn}};

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed self-checking bench for mem_req_arbiter with
//               hand-computed expected values (OUTSTANDING = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [1:0]  inst_size_i;
    logic        inst_addr_ok_o, inst_data_ok_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i, data_wr_i;
    logic [1:0]  data_size_i;
    logic [3:0]  data_wstrb_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_addr_ok_o, data_data_ok_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_wr_o;
    logic [1:0]  mem_size_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_addr_ok_i, mem_data_ok_i;
    logic [31:0] mem_rdata_i;

    int vectors;
    int miscompares;

    localparam logic [31:0] c_IADDR = 32'h1c00_0000;
    localparam logic [31:0] c_DADDR = 32'h1c00_00f2;

    mem_req_arbiter #(.OUTSTANDING(2)) u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req_i     (inst_req_i),
        .inst_addr_i    (inst_addr_i),
        .inst_size_i    (inst_size_i),
        .inst_addr_ok_o (inst_addr_ok_o),
        .inst_data_ok_o (inst_data_ok_o),
        .inst_rdata_o   (inst_rdata_o),
        .data_req_i     (data_req_i),
        .data_wr_i      (data_wr_i),
        .data_size_i    (data_size_i),
        .data_wstrb_i   (data_wstrb_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_addr_ok_o (data_addr_ok_o),
        .data_data_ok_o (data_data_ok_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_wr_o       (mem_wr_o),
        .mem_size_o     (mem_size_o),
        .mem_wstrb_o    (mem_wstrb_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_addr_ok_i  (mem_addr_ok_i),
        .mem_data_ok_i  (mem_data_ok_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven
    // for the new cycle and outputs checked #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req_i    = 1'b0;
        inst_addr_i   = c_IADDR;
        inst_size_i   = 2'd2;
        data_req_i    = 1'b0;
        data_wr_i     = 1'b0;
        data_size_i   = 2'd0;
        data_wstrb_i  = 4'd0;
        data_addr_i   = c_DADDR;
        data_wdata_i  = 32'd0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b0;
        mem_rdata_i   = 32'd0;
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) cyc();
        resetn = 1'b1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_iaok"},    {31'd0, inst_addr_ok_o}, 32'd0);
        chk({tag, "_daok"},    {31'd0, data_addr_ok_o}, 32'd0);
        chk({tag, "_idok"},    {31'd0, inst_data_ok_o}, 32'd0);
        chk({tag, "_ddok"},    {31'd0, data_data_ok_o}, 32'd0);
        chk({tag, "_maddr"},   mem_addr_o, 32'd0);
        chk({tag, "_irdata"},  inst_rdata_o, 32'd0);
        chk({tag, "_drdata"},  data_rdata_o, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        clear_inputs();

        // ---------------- reset state with noisy inputs ----------------
        inst_req_i    = 1'b1;
        data_req_i    = 1'b1;
        mem_addr_ok_i = 1'b1;
        mem_data_ok_i = 1'b1;
        mem_rdata_i   = 32'hdead_beef;
        repeat (2) cyc();
        #1;
        chk_quiet("rst");

        // ---------------- single IF read ----------------
        reset_dut();
        data_wr_i    = 1'b1;            // idle data fields must not leak
        data_wstrb_i = 4'hf;
        data_wdata_i = 32'h5555_aaaa;
        inst_req_i   = 1'b1;
        #1 chk("if_t0_mem_req", {31'd0, mem_req_o}, 32'd0);
        cyc(); #1;
        chk("if_t1_mem_req", {31'd0, mem_req_o}, 32'd1);
        chk("if_t1_addr",    mem_addr_o, c_IADDR);
        chk("if_t1_wr",      {31'd0, mem_wr_o}, 32'd0);
        chk("if_t1_wstrb",   {28'd0, mem_wstrb_o}, 32'd0);
        chk("if_t1_wdata",   mem_wdata_o, 32'd0);
        chk("if_t1_size",    {30'd0, mem_size_o}, 32'd2);
        chk("if_t1_iaok",    {31'd0, inst_addr_ok_o}, 32'd0);
        cyc(); mem_addr_ok_i = 1'b1; #1;
        chk("if_t2_iaok",    {31'd0, inst_addr_ok_o}, 32'd1);
        chk("if_t2_daok",    {31'd0, data_addr_ok_o}, 32'd0);
        cyc(); mem_addr_ok_i = 1'b0; inst_req_i = 1'b0; #1;
        chk("if_t3_bubble",  {31'd0, mem_req_o}, 32'd0);
        cyc(); mem_data_ok_i = 1'b1; mem_rdata_i = 32'h0280_0c0c; #1;
        chk("if_t4_idok",    {31'd0, inst_data_ok_o}, 32'd1);
        chk("if_t4_irdata",  inst_rdata_o, 32'h0280_0c0c);
        chk("if_t4_ddok",    {31'd0, data_data_ok_o}, 32'd0);
        cyc(); #1;
        chk("if_t5_spur_i",  {31'd0, inst_data_ok_o}, 32'd0);
        chk("if_t5_spur_d",  {31'd0, data_data_ok_o}, 32'd0);

        // ---------------- tie from reset ----------------
        reset_dut();
        inst_req_i = 1'b1;
        data_req_i = 1'b1;
        cyc(); mem_addr_ok_i = 1'b1; #1;                 // first grant
        chk("tie_g1_addr", mem_addr_o, c_DADDR);
        chk("tie_g1_daok", {31'd0, data_addr_ok_o}, 32'd1);
        cyc(); mem_addr_ok_i = 1'b0; #1;
        chk("tie_bubble",  {31'd0, mem_req_o}, 32'd0);
        cyc(); mem_addr_ok_i = 1'b1; #1;                 // second grant
`ifdef MEM_ARB_RR_EN
        chk("tie_g2_addr", mem_addr_o, c_IADDR);
        chk("tie_g2_iaok", {31'd0, inst_addr_ok_o}, 32'd1);
`else
        chk("tie_g2_addr", mem_addr_o, c_DADDR);
        chk("tie_g2_daok", {31'd0, data_addr_ok_o}, 32'd1);
`endif
        cyc(); mem_addr_ok_i = 1'b0; mem_data_ok_i = 1'b1; #1;   // full, pop data tag
        chk("tie_full_req", {31'd0, mem_req_o}, 32'd0);
        chk("tie_pop1_d",   {31'd0, data_data_ok_o}, 32'd1);
        cyc(); mem_data_ok_i = 1'b0; #1;
        chk("tie_after_pop_req", {31'd0, mem_req_o}, 32'd0);
        cyc(); #1;                                           // third grant
        chk("tie_g3_req",  {31'd0, mem_req_o}, 32'd1);
        chk("tie_g3_addr", mem_addr_o, c_DADDR);
        mem_data_ok_i = 1'b1; #1;                            // pop second tag
`ifdef MEM_ARB_RR_EN
        chk("tie_pop2_i", {31'd0, inst_data_ok_o}, 32'd1);
`else
        chk("tie_pop2_d", {31'd0, data_data_ok_o}, 32'd1);
`endif

        // ---------------- store pass-through ----------------
        reset_dut();
        data_req_i   = 1'b1;
        data_wr_i    = 1'b1;
        data_size_i  = 2'd0;
        data_wstrb_i = 4'b0100;
        data_wdata_i = 32'h00ab_0000;
        inst_addr_i  = 32'h1234_5678;
        cyc(); mem_addr_ok_i = 1'b1; #1;
        chk("st_wr",    {31'd0, mem_wr_o}, 32'd1);
        chk("st_wstrb", {28'd0, mem_wstrb_o}, 32'h4);
        chk("st_addr",  mem_addr_o, 32'h1c00_00f2);
        chk("st_wdata", mem_wdata_o, 32'h00ab_0000);
        chk("st_size",  {30'd0, mem_size_o}, 32'd0);
        chk("st_daok",  {31'd0, data_addr_ok_o}, 32'd1);
        cyc(); mem_addr_ok_i = 1'b0; data_req_i = 1'b0; #1;
        cyc(); mem_data_ok_i = 1'b1; #1;
        chk("st_ddok",  {31'd0, data_data_ok_o}, 32'd1);
        chk("st_idok",  {31'd0, inst_data_ok_o}, 32'd0);

        // ---------------- outstanding limit + push/pop ----------------
        reset_dut();
        inst_addr_i = c_IADDR;
        inst_req_i  = 1'b1;
        cyc(); mem_addr_ok_i = 1'b1; #1;                         // c1 IF accepted
        chk("ol_c1_iaok", {31'd0, inst_addr_ok_o}, 32'd1);
        cyc(); mem_addr_ok_i = 1'b0; inst_req_i = 1'b0; data_req_i = 1'b1; #1;
        cyc(); mem_addr_ok_i = 1'b1; #1;                         // c3 data accepted
        chk("ol_c3_daok", {31'd0, data_addr_ok_o}, 32'd1);
        cyc(); mem_addr_ok_i = 1'b0; data_req_i = 1'b0; inst_req_i = 1'b1; #1;
        chk("ol_c4_req",  {31'd0, mem_req_o}, 32'd0);
        cyc(); mem_data_ok_i = 1'b1; mem_rdata_i = 32'h0000_1111; #1;  // u = c5
        chk("ol_c5_req",  {31'd0, mem_req_o}, 32'd0);
        chk("ol_c5_idok", {31'd0, inst_data_ok_o}, 32'd1);
        chk("ol_c5_ddok", {31'd0, data_data_ok_o}, 32'd0);
        cyc(); mem_data_ok_i = 1'b0; #1;
        chk("ol_u1_req",  {31'd0, mem_req_o}, 32'd0);
        cyc(); #1;
        chk("ol_u2_req",  {31'd0, mem_req_o}, 32'd1);
        chk("ol_u2_addr", mem_addr_o, c_IADDR);
        // push IF and pop the data tag in the same cycle, count stays 1
        mem_addr_ok_i = 1'b1; mem_data_ok_i = 1'b1; #1;
        chk("pp_iaok",    {31'd0, inst_addr_ok_o}, 32'd1);
        chk("pp_ddok",    {31'd0, data_data_ok_o}, 32'd1);
        chk("pp_idok",    {31'd0, inst_data_ok_o}, 32'd0);
        cyc(); mem_addr_ok_i = 1'b0; mem_data_ok_i = 1'b0; inst_req_i = 1'b0; #1;
        cyc(); mem_data_ok_i = 1'b1; #1;
        chk("pp_head_i",  {31'd0, inst_data_ok_o}, 32'd1);
        chk("pp_head_d",  {31'd0, data_data_ok_o}, 32'd0);
        cyc(); #1;                                               // FIFO now empty
        chk("spur_i",     {31'd0, inst_data_ok_o}, 32'd0);
        chk("spur_d",     {31'd0, data_data_ok_o}, 32'd0);

        // ---------------- reset in GRANT_D with count 1 ----------------
        reset_dut();
        data_req_i = 1'b1;
        data_wr_i  = 1'b1;
        data_wstrb_i = 4'hf;
        data_wdata_i = 32'hcafe_f00d;
        cyc(); mem_addr_ok_i = 1'b1; #1;
        cyc(); mem_addr_ok_i = 1'b0; #1;
        cyc(); #1;
        chk("mr_grant_d", {31'd0, mem_req_o}, 32'd1);
        resetn = 1'b0;
        mem_rdata_i = 32'h7777_7777;
        cyc(); #1;
        chk_quiet("mr");
        chk("mr_wdata",   mem_wdata_o, 32'd0);
        chk("mr_wr",      {31'd0, mem_wr_o}, 32'd0);
        resetn = 1'b1; data_req_i = 1'b0; mem_data_ok_i = 1'b1; #1;
        chk("mr_drop_i",  {31'd0, inst_data_ok_o}, 32'd0);
        chk("mr_drop_d",  {31'd0, data_data_ok_o}, 32'd0);
        cyc(); mem_data_ok_i = 1'b0; #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
